nibble_serial_add_ctrl: RTL and testbench

- Upstream sequencer for the registered 4-bit adder stage (4-bit data_a/data_b plus c_in in; sum/c_out registered out, 1-cycle latency).
- Splits WIDTH-bit operands into nibbles, issues one nibble per cycle LSB-first, and feeds the adder's registered c_out back as the next c_in.
- Collects the registered sums into a WIDTH-bit result and pulses done.
- Gives the datapath a wide adder built on the single 4-bit stage.

---
 rtl/nibble_serial_add_ctrl_pkg.sv | 23 ++
 rtl/adder4_reg.sv | 28 ++
 rtl/nibble_serial_add_ctrl.sv | 119 +++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared constants, state encoding and sizing helper for the nibble-serial adder sequencer.
package nibble_serial_add_ctrl_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/adder4_reg.sv
// Registered 4-bit adder stage: {c_out, sum} = data_a + data_b + c_in, one cycle of latency.
module adder4_reg
    import nibble_serial_add_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [NIB_W-1:0] data_a,
    input  logic [NIB_W-1:0] data_b,
    input  logic             c_in,
    output logic [NIB_W-1:0] sum,
    output logic             c_out
);

    logic [NIB_W-1:0] sum_q;
    logic             c_out_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {c_out_q, sum_q} <= '0;
        end else begin
            {c_out_q, sum_q} <= {1'b0, data_a} + {1'b0, data_b} + {{NIB_W{1'b0}}, c_in};
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Sequences WIDTH-bit operands through the external registered 4-bit adder LSB nibble first,
// chaining its registered carry, and assembles the result; done pulses NIB+1 cycles after start.
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             carry_in,
    output logic             ready,
    output logic [NIB_W-1:0] data_a,
    output logic [NIB_W-1:0] data_b,
    output logic             c_in,
    input  logic [NIB_W-1:0] sum,
    input  logic             c_out,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             done
);

    localparam int NIB = WIDTH / NIB_W;
    localparam int CW  = clog2(NIB);

    state_e           state_q, state_d;
    logic [CW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cin_q, cin_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        done_d      = 1'b0;
        ready       = 1'b0;
        data_a      = '0;
        data_b      = '0;
        c_in        = 1'b0;

        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    cin_d   = carry_in;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NIB; i++) begin
                    if (k_q == CW'(i)) begin
                        data_a = a_q[i*NIB_W +: NIB_W];
                        data_b = b_q[i*NIB_W +: NIB_W];
                    end
                end
                // Nibble 0 takes the latched carry; later nibbles take the adder's registered carry.
                c_in = (k_q == '0) ? cin_q : c_out;
                for (int i = 0; i < NIB - 1; i++) begin
                    if (k_q == CW'(i + 1)) result_d[i*NIB_W +: NIB_W] = sum;
                end
                if (k_q == CW'(NIB - 1)) begin
                    state_d = FLUSH;
                end else begin
                    k_d = k_q + CW'(1);
                end
            end
            FLUSH: begin
                result_d[WIDTH-1 -: NIB_W] = sum;
                carry_out_d                = c_out;
                done_d                     = 1'b1;
                k_d                        = '0;
                state_d                    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign done      = done_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for the sequencer wired to the registered 4-bit adder; table vectors, corner sequences, random ops.
module tb_nibble_serial_add_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry_in;
    logic             ready;
    logic [3:0]       data_a;
    logic [3:0]       data_b;
    logic             c_in;
    logic [3:0]       sum;
    logic             c_out;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             done;

    int checks     = 0;
    int errors     = 0;
    int starts     = 0;
    int aborted    = 0;
    int done_cnt   = 0;

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .carry_in(carry_in), .ready(ready), .data_a(data_a), .data_b(data_b),
        .c_in(c_in), .sum(sum), .c_out(c_out), .result(result),
        .carry_out(carry_out), .done(done)
    );

    adder4_reg u_adder (
        .clk(clk), .reset(reset), .data_a(data_a), .data_b(data_b),
        .c_in(c_in), .sum(sum), .c_out(c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain wide addition.
    function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic ci);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    endfunction

    // Carry entering nibble k is the carry out of the low 4k bits of the sum.
    function automatic logic [NIB-1:0] ref_cin_mask(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b, input logic ci);
        logic [NIB-1:0] m;
        longint unsigned lo, s;
        m = '0;
        for (int k = 0; k < NIB; k++) begin
            lo = (64'd1 << (4 * k)) - 64'd1;
            s  = (longint'(a) & lo) + (longint'(b) & lo) + longint'(ci);
            m[k] = s[4*k];
        end
        return m;
    endfunction

    // Issues one op at the current negedge and returns at the negedge where done is seen.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci,
                          input int poke, output logic [WIDTH-1:0] res, output logic co,
                          output int lat, output int rlow, output logic [NIB-1:0] cmask);
        check("ready_before_start", ready, 1);
        op_a = a; op_b = b; carry_in = ci; start = 1'b1;
        @(posedge clk);
        starts++;
        @(negedge clk);
        start = 1'b0;
        op_a = WIDTH'($urandom); op_b = WIDTH'($urandom); carry_in = 1'($urandom);
        lat = -1; rlow = 0; cmask = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk);
                @(negedge clk);
                start = 1'b0;
            end
            if (cyc == 0) check("done_single_pulse", done, 0);
            if (done === 1'b1) begin
                lat = cyc;
                break;
            end
            if (ready !== 1'b1) rlow++;
            if (cyc < NIB) cmask[cyc] = c_in;
            if (cyc == poke) begin
                start = 1'b1; op_a = 16'hAAAA; op_b = 16'h5555; carry_in = 1'b1;
            end
        end
        res = result;
        co  = carry_out;
    endtask

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             ci;
        logic [WIDTH-1:0] res;
        logic             co;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [WIDTH-1:0] res;
        logic             co;
        logic [WIDTH:0]   exp_s;
        logic [NIB-1:0]   cmask;
        int               lat, rlow;
        bit               saw_done;

        vecs[0] = '{a: 16'h1234, b: 16'h4321, ci: 1'b0, res: 16'h5555, co: 1'b0};
        vecs[1] = '{a: 16'hFFFF, b: 16'h0001, ci: 1'b0, res: 16'h0000, co: 1'b1};
        vecs[2] = '{a: 16'hFFFF, b: 16'hFFFF, ci: 1'b1, res: 16'hFFFF, co: 1'b1};
        vecs[3] = '{a: 16'h0000, b: 16'h0000, ci: 1'b1, res: 16'h0001, co: 1'b0};
        vecs[4] = '{a: 16'h8000, b: 16'h8000, ci: 1'b0, res: 16'h0000, co: 1'b1};
        vecs[5] = '{a: 16'h0F0F, b: 16'h00F1, ci: 1'b0, res: 16'h1000, co: 1'b0};

        reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0; carry_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_result", {carry_out, result}, 0);
        check("rst_data", {c_in, data_b, data_a}, 0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].ci, -1, res, co, lat, rlow, cmask);
            check("vec_result", res, vecs[i].res);
            check("vec_carry_out", co, vecs[i].co);
            check("vec_latency", lat, NIB + 1);
            check("vec_ready_low", rlow, NIB + 1);
            check("vec_cin_seq", cmask, ref_cin_mask(vecs[i].a, vecs[i].b, vecs[i].ci));
        end

        // start during RUN must be ignored; start in the done cycle is taken back-to-back.
        run_op(16'h1234, 16'h4321, 1'b0, 2, res, co, lat, rlow, cmask);
        check("poke_result", {co, res}, 17'h05555);
        check("poke_latency", lat, NIB + 1);
        run_op(16'h0001, 16'h0002, 1'b0, -1, res, co, lat, rlow, cmask);
        check("b2b_result", {co, res}, 17'h00003);
        check("b2b_latency", lat, NIB + 1);
        saw_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1;
        end
        check("no_extra_done", saw_done, 0);
        check("idle_ready", ready, 1);

        // Abort mid-operation at nibble 2.
        op_a = 16'h1234; op_b = 16'h1111; carry_in = 1'b0; start = 1'b1;
        @(posedge clk);
        starts++;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check("k2_data_a", data_a, 4'h2);
        reset = 1'b1;
        aborted++;
        #1;
        check("abort_data", {c_in, data_b, data_a}, 0);
        check("abort_result", {carry_out, result}, 0);
        check("abort_done", done, 0);
        check("abort_ready", ready, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1;
        end
        check("abort_no_done", saw_done, 0);
        run_op(16'h00F0, 16'h0010, 1'b0, -1, res, co, lat, rlow, cmask);
        check("post_abort_result", {co, res}, 17'h00100);
        check("post_abort_latency", lat, NIB + 1);

        for (int n = 0; n < 500; n++) begin
            logic [WIDTH-1:0] ra, rb;
            logic             rc;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            if (n % 7 == 0) rb = ~ra;
            exp_s = ref_sum(ra, rb, rc);
            run_op(ra, rb, rc, -1, res, co, lat, rlow, cmask);
            check("rand_sum", {co, res}, exp_s);
            check("rand_latency", lat, NIB + 1);
            check("rand_cin_seq", cmask, ref_cin_mask(ra, rb, rc));
            if (n % 50 == 7) begin
                for (int g = 0; g < int'($urandom_range(0, 3)); g++) @(negedge clk);
            end
        end

        @(negedge clk);
        check("done_count", done_cnt, starts - aborted);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
